// File: rtl/digital_theremin_pio_pkg.sv
// Shared constants for the theremin PIO slaves: register map, edge
// selection codes, pulse FSM state type and the readback busy-bit position.
package digital_theremin_pio_pkg;

  localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
  localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_PULSE    = 3'd6;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int PULSE_BUSY_BIT = 31;

  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/digital_theremin_pio_ext_edge_sync.sv
// Three-stage input synchroniser with per-bit edge detection.
// sync_o is the second stage (first one considered metastability-safe);
// the third stage is only used as the "previous" value for edge detection.
module pio_edge_sync
  import digital_theremin_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] s3_q;

  // Shift the asynchronous inputs through three flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Select the edge polarity from the elaboration-time parameter.
  always_comb begin
    edge_o = '0;
    case (EDGE_TYPE)
      EDGE_FALL: edge_o = ~s2_q & s3_q;
      EDGE_ANY:  edge_o = s2_q ^ s3_q;
      default:   edge_o = s2_q & ~s3_q;
    endcase
  end

  assign sync_o = s2_q;

endmodule

// File: rtl/digital_theremin_pio_ext.sv
// Avalon-MM PIO slave, WIDTH bits wide: output register with atomic
// set/clear and a self-timed pulse mode, plus a synchronised input port
// with edge capture and a maskable level interrupt. Read latency is zero.
//
// Bus handshake: there is no wait-request; a write is accepted in every
// cycle where chipselect=1 and write_n=0, and readdata is valid in the same
// cycle as address. Upper writedata bits beyond WIDTH are ignored.
module digital_theremin_pio_ext
  import digital_theremin_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               PULSE_LEN   = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             wr;
  logic [WIDTH-1:0] wd;

  logic [WIDTH-1:0] data_out_q,   data_out_d;
  logic [WIDTH-1:0] irq_mask_q,   irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q,   edge_cap_d;
  logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  pulse_state_e     state_q,      state_d;

  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_edge;
  logic             busy;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_hi_unused
    logic unused_wd_hi;
    assign unused_wd_hi = ^writedata[31:WIDTH];
  end

  pio_edge_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .in_i    (in_port),
    .sync_o  (in_sync),
    .edge_o  (in_edge)
  );

  // Register file next-state: data_out write/set/clear, mask, edge capture.
  always_comb begin
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    if (wr) begin
      case (address)
        ADDR_DATA_OUT: data_out_d = wd;
        ADDR_OUTSET:   data_out_d = data_out_q | wd;
        ADDR_OUTCLR:   data_out_d = data_out_q & ~wd;
        ADDR_IRQ_MASK: irq_mask_d = wd;
        default:       ;
      endcase
    end
    // A fresh edge in the clearing cycle keeps its bit set.
    edge_cap_d = edge_cap_q | in_edge;
    if (wr && address == ADDR_EDGE_CAP) begin
      edge_cap_d = (edge_cap_q & ~wd) | in_edge;
    end
  end

  // Pulse FSM next-state: load/retrigger, abort, or count down to idle.
  always_comb begin
    state_d      = state_q;
    pulse_mask_d = pulse_mask_q;
    cnt_d        = cnt_q;
    if (wr && address == ADDR_PULSE) begin
      if (wd != '0) begin
        pulse_mask_d = wd;
        cnt_d        = CNT_LOAD;
        state_d      = PULSE_ACTIVE;
      end else begin
        pulse_mask_d = '0;
        cnt_d        = '0;
        state_d      = PULSE_IDLE;
      end
    end else if (state_q == PULSE_ACTIVE) begin
      if (cnt_q == CNT_ONE) begin
        pulse_mask_d = '0;
        cnt_d        = '0;
        state_d      = PULSE_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // State registers; reset drops any pulse immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q   <= RESET_VALUE;
      irq_mask_q   <= '0;
      edge_cap_q   <= '0;
      pulse_mask_q <= '0;
      cnt_q        <= '0;
      state_q      <= PULSE_IDLE;
    end else begin
      data_out_q   <= data_out_d;
      irq_mask_q   <= irq_mask_d;
      edge_cap_q   <= edge_cap_d;
      pulse_mask_q <= pulse_mask_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
    end
  end

  assign busy     = (state_q == PULSE_ACTIVE);
  assign out_port = data_out_q ^ pulse_mask_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

  // Zero-latency read mux; write-only and reserved addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA_OUT: readdata = 32'(data_out_q);
      ADDR_DATA_IN:  readdata = 32'(in_sync);
      ADDR_IRQ_MASK: readdata = 32'(irq_mask_q);
      ADDR_EDGE_CAP: readdata = 32'(edge_cap_q);
      ADDR_PULSE: begin
        readdata                 = 32'(pulse_mask_q);
        readdata[PULSE_BUSY_BIT] = busy;
      end
      default:       readdata = '0;
    endcase
  end

endmodule
